// File: rtl/rx_serial_7o1_pkg.sv
// Shared definitions for the 7O1 serial link: FSM state codes, frame
// constants and default line timing (also used by the transmitter).
package rx_serial_7o1_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'h0,
    ST_START    = 4'h1,
    ST_DADOS    = 4'h2,
    ST_PARIDADE = 4'h3,
    ST_STOP     = 4'h4,
    ST_FINAL    = 4'h5
  } state_t;

  // 7O1 frame: 7 data bits, odd parity, 1 stop bit
  localparam int DATA_BITS  = 7;
  localparam bit PARITY_ODD = 1'b1;

  localparam int DEFAULT_CLOCK_FREQ = 50_000_000;
  localparam int DEFAULT_BAUD       = 115200;

  // Bit-time counter width (holds up to 511 clocks per bit)
  localparam int CNT_W = 9;

  // High when data+parity do not carry the expected parity
  function automatic logic parity_error(input logic [DATA_BITS-1:0] data,
                                        input logic                 par);
    return (^{data, par}) != PARITY_ODD;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear and count enable.
module contador_m #(
  parameter int M = 434,
  parameter int N = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [N-1:0] Q
);

  // Count while enabled, wrap at M-1, synchronous clear has priority
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Q <= '0;
    end else if (zera) begin
      Q <= '0;
    end else if (conta) begin
      if (Q == N'(M - 1)) Q <= '0;
      else                Q <= Q + 1'b1;
    end
  end

endmodule

// File: rtl/rx_serial_7o1_fsm.sv
// Receive FSM and datapath for 7O1 frames: mid-bit sampling, shift
// register, parity/stop checks and the consumer handshake.
module rx_serial_7o1_fsm
  import rx_serial_7o1_pkg::*;
#(
  parameter int BIT_CYCLES  = 434,
  parameter int HALF_CYCLES = 217
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_rx,
  input  logic                 i_recebe,
  output logic [DATA_BITS-1:0] o_dados_ascii,
  output logic                 o_pronto,
  output logic                 o_tem_dado,
  output logic                 o_erro_paridade,
  output logic                 o_erro_stop,
  output logic                 o_erro_sobrescrita,
  output logic [3:0]           o_db_estado,
  output logic                 o_db_tick
);

  state_t               r_state;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_stop;
  logic [CNT_W-1:0]     w_cnt;
  logic                 w_tick;
  logic                 w_zera;
  logic                 w_conta;

  contador_m #(.M(BIT_CYCLES), .N(CNT_W)) u_cnt (
    .clock (i_clock),
    .reset (i_reset),
    .zera  (w_zera),
    .conta (w_conta),
    .Q     (w_cnt)
  );

  // Sample strobe: half a bit into START, a full bit in the other states
  always_comb begin
    w_tick = 1'b0;
    case (r_state)
      ST_START:                       w_tick = (w_cnt == CNT_W'(HALF_CYCLES - 1));
      ST_DADOS, ST_PARIDADE, ST_STOP: w_tick = (w_cnt == CNT_W'(BIT_CYCLES - 1));
      default:                        w_tick = 1'b0;
    endcase
  end

  // Counter held at zero in IDLE so START begins from a clean count
  assign w_zera  = (r_state == ST_IDLE) || w_tick;
  assign w_conta = (r_state == ST_START) || (r_state == ST_DADOS) ||
                   (r_state == ST_PARIDADE) || (r_state == ST_STOP);

  assign o_db_estado = r_state;
  assign o_db_tick   = w_tick;

  // Data bits shift in LSB first; holds its value outside DADOS
  always_ff @(posedge i_clock) begin
    if (r_state == ST_DADOS && w_tick) r_shift <= {i_rx, r_shift[DATA_BITS-1:1]};
  end

  // Frame sequencing, output registers and handshake flags
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state            <= ST_IDLE;
      r_bit_idx          <= '0;
      r_par              <= 1'b0;
      r_stop             <= 1'b0;
      o_dados_ascii      <= '0;
      o_pronto           <= 1'b0;
      o_tem_dado         <= 1'b0;
      o_erro_paridade    <= 1'b0;
      o_erro_stop        <= 1'b0;
      o_erro_sobrescrita <= 1'b0;
    end else begin
      o_pronto <= 1'b0;
      if (i_recebe && o_tem_dado) begin
        o_tem_dado         <= 1'b0;
        o_erro_sobrescrita <= 1'b0;
      end
      case (r_state)
        ST_IDLE: if (!i_rx) r_state <= ST_START;
        ST_START: begin
          if (w_tick) begin
            if (i_rx) begin
              r_state <= ST_IDLE;
            end else begin
              r_state   <= ST_DADOS;
              r_bit_idx <= '0;
            end
          end
        end
        ST_DADOS: begin
          if (w_tick) begin
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'(DATA_BITS - 1)) r_state <= ST_PARIDADE;
          end
        end
        ST_PARIDADE: begin
          if (w_tick) begin
            r_par   <= i_rx;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_stop  <= i_rx;
            r_state <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          o_dados_ascii   <= r_shift;
          o_erro_paridade <= parity_error(r_shift, r_par);
          o_erro_stop     <= ~r_stop;
          o_pronto        <= 1'b1;
          o_tem_dado      <= 1'b1;
          // Unread data overwritten; an ack in this same cycle consumes it
          if (o_tem_dado && !i_recebe) o_erro_sobrescrita <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rx_serial_7o1.sv
// 7O1 asynchronous serial receiver: two-flop input synchronizer in
// front of the receive FSM.
module rx_serial_7o1
  import rx_serial_7o1_pkg::*;
#(
  parameter int CLOCK_FREQ  = DEFAULT_CLOCK_FREQ,
  parameter int BAUD        = DEFAULT_BAUD,
  parameter int BIT_CYCLES  = CLOCK_FREQ / BAUD,
  parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dados_serial,
  input  logic       recebe,
  output logic [6:0] dados_ascii,
  output logic       pronto,
  output logic       tem_dado,
  output logic       erro_paridade,
  output logic       erro_stop,
  output logic       erro_sobrescrita,
  output logic [3:0] db_estado,
  output logic       db_tick
);

  logic r_sync1;
  logic r_sync2;

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= dados_serial;
      r_sync2 <= r_sync1;
    end
  end

  rx_serial_7o1_fsm #(
    .BIT_CYCLES  (BIT_CYCLES),
    .HALF_CYCLES (HALF_CYCLES)
  ) u_fsm (
    .i_clock            (clock),
    .i_reset            (reset),
    .i_rx               (r_sync2),
    .i_recebe           (recebe),
    .o_dados_ascii      (dados_ascii),
    .o_pronto           (pronto),
    .o_tem_dado         (tem_dado),
    .o_erro_paridade    (erro_paridade),
    .o_erro_stop        (erro_stop),
    .o_erro_sobrescrita (erro_sobrescrita),
    .o_db_estado        (db_estado),
    .o_db_tick          (db_tick)
  );

endmodule

// File: tb/tb_rx_serial_7o1.sv
// Directed bench for rx_serial_7o1: frames are bit-banged on the RX
// line and the held character and flags are compared to hand values.
module tb_rx_serial_7o1;

  localparam int BITC = 434;

  logic       clock = 1'b0;
  logic       reset;
  logic       dados_serial;
  logic       recebe;
  logic [6:0] dados_ascii;
  logic       pronto;
  logic       tem_dado;
  logic       erro_paridade;
  logic       erro_stop;
  logic       erro_sobrescrita;
  logic [3:0] db_estado;
  logic       db_tick;

  int n_vec    = 0;
  int n_err    = 0;
  int n_pronto = 0;
  int p0       = 0;
  int base     = 0;
  int k        = 0;
  int found    = 0;
  int n_ticks  = 0;

  always #5 clock = ~clock;

  rx_serial_7o1 #(.CLOCK_FREQ(50_000_000), .BAUD(115200)) dut (
    .clock            (clock),
    .reset            (reset),
    .dados_serial     (dados_serial),
    .recebe           (recebe),
    .dados_ascii      (dados_ascii),
    .pronto           (pronto),
    .tem_dado         (tem_dado),
    .erro_paridade    (erro_paridade),
    .erro_stop        (erro_stop),
    .erro_sobrescrita (erro_sobrescrita),
    .db_estado        (db_estado),
    .db_tick          (db_tick)
  );

  // Count completed frames and sample strobes, observed mid-cycle
  always @(negedge clock) begin
    if (pronto === 1'b1)  n_pronto <= n_pronto + 1;
    if (db_tick === 1'b1) n_ticks  <= n_ticks + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [6:0] d, input logic p, input logic s,
                            input int bitc, input int stop_len);
    dados_serial = 1'b0;
    cycles(bitc);
    for (int i = 0; i < 7; i++) begin
      dados_serial = d[i];
      cycles(bitc);
    end
    dados_serial = p;
    cycles(bitc);
    dados_serial = s;
    cycles(stop_len);
    dados_serial = 1'b1;
  endtask

  task automatic pulse_recebe();
    recebe = 1'b1;
    cycles(1);
    recebe = 1'b0;
    cycles(1);
  endtask

  initial begin
    // Power-on reset
    reset        = 1'b0;
    dados_serial = 1'b1;
    recebe       = 1'b0;
    cycles(3);
    check("rst_dados",  dados_ascii, 7'h00);
    check("rst_pronto", pronto, 1'b0);
    check("rst_tem",    tem_dado, 1'b0);
    check("rst_epar",   erro_paridade, 1'b0);
    check("rst_estop",  erro_stop, 1'b0);
    check("rst_esob",   erro_sobrescrita, 1'b0);
    check("rst_estado", db_estado, 4'h0);
    reset = 1'b1;
    cycles(10);

    // Clean 'A' (0x41, two ones -> parity 1)
    p0 = n_pronto;
    n_ticks = 0;
    cycles(1);
    send_frame(7'h41, 1'b1, 1'b1, BITC, BITC);
    cycles(20);
    check("A_pronto", n_pronto - p0, 1);
    check("A_ticks",  n_ticks, 10);
    check("A_dados",  dados_ascii, 7'h41);
    check("A_epar",   erro_paridade, 1'b0);
    check("A_estop",  erro_stop, 1'b0);
    check("A_tem",    tem_dado, 1'b1);
    check("A_esob",   erro_sobrescrita, 1'b0);
    pulse_recebe();
    check("A_ack_tem",   tem_dado, 1'b0);
    check("A_ack_dados", dados_ascii, 7'h41);

    // Async reset mid-frame (line low = start bit followed by zeros)
    p0 = n_pronto;
    dados_serial = 1'b0;
    cycles(1500);
    check("mid_estado", db_estado, 4'h2);
    reset = 1'b0;
    dados_serial = 1'b1;
    cycles(3);
    check("mid_rst_dados",  dados_ascii, 7'h00);
    check("mid_rst_estado", db_estado, 4'h0);
    check("mid_rst_tem",    tem_dado, 1'b0);
    check("mid_rst_pronto", pronto, 1'b0);
    reset = 1'b1;
    cycles(5000);
    check("mid_no_pronto", n_pronto - p0, 0);
    check("mid_idle",      db_estado, 4'h0);

    // '#' (0x23, three ones) with parity forced to 1 -> even total
    p0 = n_pronto;
    send_frame(7'h23, 1'b1, 1'b1, BITC, BITC);
    cycles(20);
    check("P_pronto", n_pronto - p0, 1);
    check("P_dados",  dados_ascii, 7'h23);
    check("P_epar",   erro_paridade, 1'b1);
    check("P_estop",  erro_stop, 1'b0);
    pulse_recebe();

    // 'A' with stop bit sampled low; line released soon after midpoint
    p0 = n_pronto;
    send_frame(7'h41, 1'b1, 1'b0, BITC, BITC / 2 + 50);
    cycles(600);
    check("S_pronto", n_pronto - p0, 1);
    check("S_dados",  dados_ascii, 7'h41);
    check("S_estop",  erro_stop, 1'b1);
    check("S_epar",   erro_paridade, 1'b0);
    check("S_idle",   db_estado, 4'h0);

    // Glitch: 100 cycles low then high, character from above still held
    p0 = n_pronto;
    dados_serial = 1'b0;
    cycles(50);
    check("G_start", db_estado, 4'h1);
    cycles(50);
    dados_serial = 1'b1;
    cycles(400);
    check("G_idle",   db_estado, 4'h0);
    check("G_pronto", n_pronto - p0, 0);
    check("G_tem",    tem_dado, 1'b1);
    check("G_dados",  dados_ascii, 7'h41);
    pulse_recebe();

    // Overrun: two back-to-back frames without acknowledge
    p0 = n_pronto;
    send_frame(7'h41, 1'b1, 1'b1, BITC, BITC);
    send_frame(7'h23, 1'b0, 1'b1, BITC, BITC);
    cycles(20);
    check("O_pronto", n_pronto - p0, 2);
    check("O_dados",  dados_ascii, 7'h23);
    check("O_esob",   erro_sobrescrita, 1'b1);
    check("O_epar",   erro_paridade, 1'b0);
    pulse_recebe();
    check("O_ack_esob", erro_sobrescrita, 1'b0);
    check("O_ack_tem",  tem_dado, 1'b0);

    // Acknowledge coinciding with the second frame's FINAL cycle
    found = 0;
    fork
      begin
        send_frame(7'h41, 1'b1, 1'b1, BITC, BITC);
        send_frame(7'h23, 1'b0, 1'b1, BITC, BITC);
      end
      begin
        base = n_pronto;
        k = 0;
        while (n_pronto == base && k < 6000) begin cycles(1); k++; end
        k = 0;
        while (db_estado !== 4'h5 && k < 6000) begin cycles(1); k++; end
        found = (db_estado === 4'h5) ? 1 : 0;
        recebe = 1'b1;
        cycles(1);
        recebe = 1'b0;
      end
    join
    cycles(20);
    check("C_final_seen", found, 1);
    check("C_dados", dados_ascii, 7'h23);
    check("C_tem",   tem_dado, 1'b1);
    check("C_esob",  erro_sobrescrita, 1'b0);
    pulse_recebe();

    // Baud tolerance: -4% and +4% bit periods
    p0 = n_pronto;
    send_frame(7'h41, 1'b1, 1'b1, 417, 417);
    cycles(20);
    check("F_pronto", n_pronto - p0, 1);
    check("F_dados",  dados_ascii, 7'h41);
    check("F_err",    {erro_paridade, erro_stop}, 2'b00);
    pulse_recebe();

    p0 = n_pronto;
    send_frame(7'h41, 1'b1, 1'b1, 451, 451);
    cycles(20);
    check("L_pronto", n_pronto - p0, 1);
    check("L_dados",  dados_ascii, 7'h41);
    check("L_err",    {erro_paridade, erro_stop}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
